// File: rtl/patch_pkg.sv
// rtl/patch_pkg.sv - shared types and constants for the patch dispatch controller
package patch_pkg;

    localparam int IMG_WIDTH_DEF         = 64;
    localparam int IMG_HEIGHT_DEF        = 64;
    localparam int PATCH_SIZE_DEF        = 16;
    localparam int TOTAL_NUM_PATCHES_DEF = (IMG_WIDTH_DEF / PATCH_SIZE_DEF) * (IMG_HEIGHT_DEF / PATCH_SIZE_DEF);

    // Patchifier state encoding as driven on pf_state
    localparam logic [1:0] PF_IDLE       = 2'b00;
    localparam logic [1:0] PF_PROCESSING = 2'b01;
    localparam logic [1:0] PF_DONE       = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_STREAM,
        ST_RELEASE,
        ST_ERROR
    } dispatch_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(TOTAL_NUM_PATCHES_DEF);

endpackage

// File: rtl/patch_watchdog.sv
// rtl/patch_watchdog.sv - saturating cycle counter flagging expiry at LIMIT-1
module patch_watchdog #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count;

    // Holds at the expiry value so it never wraps back below the limit
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/patch_dispatch_ctrl.sv
// rtl/patch_dispatch_ctrl.sv - launches the patchifier per frame and streams patch indices downstream
module patch_dispatch_ctrl
    import patch_pkg::*;
#(
    parameter int IMG_WIDTH         = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT        = IMG_HEIGHT_DEF,
    parameter int PATCH_SIZE        = PATCH_SIZE_DEF,
    parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
    parameter int IDX_W             = idx_width(TOTAL_NUM_PATCHES),
    parameter int TIMEOUT_CYCLES    = IMG_WIDTH * IMG_HEIGHT + 64,
    parameter int FRAME_CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             pf_state,
    output logic                   pf_en,
    output logic                   pf_output_taken,
    output logic                   patch_valid,
    input  logic                   patch_ready,
    output logic [IDX_W-1:0]       patch_idx,
    output logic                   patch_last,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   timeout_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_NUM_PATCHES - 1);

    dispatch_state_t state;
    logic            wd_expire;

    // Counter is held clear in LAUNCH so it reads 0 on the first WAIT cycle
    patch_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_LAUNCH),
        .enable(state == ST_WAIT),
        .expire(wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            pf_en           <= 1'b0;
            pf_output_taken <= 1'b0;
            patch_valid     <= 1'b0;
            patch_idx       <= '0;
            patch_last      <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            frame_count     <= '0;
            timeout_err     <= 1'b0;
        end else begin
            pf_en           <= 1'b0;
            pf_output_taken <= 1'b0;
            frame_done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LAUNCH;
                        busy  <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    if (pf_state == PF_IDLE) begin
                        state <= ST_WAIT;
                        pf_en <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // DONE is tested first so it wins over a simultaneous expiry
                    if (pf_state == PF_DONE) begin
                        state       <= ST_STREAM;
                        patch_valid <= 1'b1;
                        patch_idx   <= '0;
                        patch_last  <= (TOTAL_NUM_PATCHES == 1);
                    end else if (wd_expire) begin
                        state       <= ST_ERROR;
                        timeout_err <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (patch_ready) begin
                        if (patch_last) begin
                            state           <= ST_RELEASE;
                            patch_valid     <= 1'b0;
                            patch_idx       <= '0;
                            patch_last      <= 1'b0;
                            pf_output_taken <= 1'b1;
                            frame_done      <= 1'b1;
                            frame_count     <= frame_count + FRAME_CNT_W'(1);
                        end else begin
                            patch_idx  <= patch_idx + IDX_W'(1);
                            patch_last <= (patch_idx + IDX_W'(1) == LAST_IDX);
                        end
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_ERROR: begin
                    patch_valid <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
